// File: rtl/fft_bitrev_reorder_if.sv
// Stream bundle for the FFT output reorder unit: bit-reversed samples in, natural-order bins out.
interface fft_bitrev_reorder_if #(
  parameter int unsigned DATA_WIDTH = 18,
  parameter int unsigned ADDR_W     = 6
);
  logic                         in_valid;
  logic                         in_start;
  logic signed [DATA_WIDTH-1:0] serial_in_r;
  logic signed [DATA_WIDTH-1:0] serial_in_i;
  logic                         out_valid;
  logic                         out_first;
  logic        [ADDR_W-1:0]     out_index;
  logic signed [DATA_WIDTH-1:0] out_r;
  logic signed [DATA_WIDTH-1:0] out_i;

  // Producer side: the FFT pipeline feeding samples and observing the reordered stream.
  modport master (
    output in_valid, in_start, serial_in_r, serial_in_i,
    input  out_valid, out_first, out_index, out_r, out_i
  );

  // Reorder unit side.
  modport slave (
    input  in_valid, in_start, serial_in_r, serial_in_i,
    output out_valid, out_first, out_index, out_r, out_i
  );
endinterface

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: writes each frame at bit-reversed addresses, reads it back linearly,
// so the serial bit-reversed FFT output leaves in natural bin order with no gaps between frames.
module fft_bitrev_reorder #(
  parameter int unsigned INTEGER_SIZE = 6,
  parameter int unsigned FRACT_SIZE   = 12,
  parameter int unsigned NFFT         = 64
) (
  input logic                 clk,
  input logic                 rst,
  fft_bitrev_reorder_if.slave bus
);
  localparam int unsigned DataWidth = INTEGER_SIZE + FRACT_SIZE;
  localparam int unsigned AddrW     = $clog2(NFFT);
  localparam logic [AddrW-1:0] LastIdx = AddrW'(NFFT - 1);

  typedef enum logic {StWIdle, StWFill} wstate_e;
  typedef enum logic {StRIdle, StRRun}  rstate_e;

  function automatic logic [AddrW-1:0] bitrev(input logic [AddrW-1:0] a);
    logic [AddrW-1:0] r;
    for (int b = 0; b < int'(AddrW); b++) begin
      r[b] = a[int'(AddrW) - 1 - b];
    end
    return r;
  endfunction

  // Two banks side by side; the bank select is the top address bit.
  logic [DataWidth-1:0] ram_r_q [2*NFFT];
  logic [DataWidth-1:0] ram_i_q [2*NFFT];

  wstate_e              wstate_q, wstate_d;
  logic [AddrW-1:0]     wcnt_q, wcnt_d;
  logic                 wbank_q, wbank_d;
  logic [1:0]           full_q, full_d;
  rstate_e              rstate_q, rstate_d;
  logic [AddrW-1:0]     rcnt_q, rcnt_d;
  logic                 rbank_q, rbank_d;

  logic                 out_valid_q, out_valid_d;
  logic                 out_first_q, out_first_d;
  logic [AddrW-1:0]     out_index_q, out_index_d;
  logic [DataWidth-1:0] out_r_q, out_r_d;
  logic [DataWidth-1:0] out_i_q, out_i_d;

  logic                 we;
  logic                 wr_done;
  logic [AddrW-1:0]     wptr;
  logic [AddrW:0]       waddr;
  logic [AddrW:0]       raddr;

  assign waddr = {wbank_q, bitrev(wptr)};
  assign raddr = {rbank_q, rcnt_q};

  // State register for both FSMs and the registered output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      wstate_q    <= StWIdle;
      wcnt_q      <= '0;
      wbank_q     <= 1'b0;
      full_q      <= '0;
      rstate_q    <= StRIdle;
      rcnt_q      <= '0;
      rbank_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_index_q <= '0;
      out_r_q     <= '0;
      out_i_q     <= '0;
    end else begin
      wstate_q    <= wstate_d;
      wcnt_q      <= wcnt_d;
      wbank_q     <= wbank_d;
      full_q      <= full_d;
      rstate_q    <= rstate_d;
      rcnt_q      <= rcnt_d;
      rbank_q     <= rbank_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_index_q <= out_index_d;
      out_r_q     <= out_r_d;
      out_i_q     <= out_i_d;
    end
  end

  // Sample memory; contents are deliberately left alone by reset.
  always_ff @(posedge clk) begin
    if (we) begin
      ram_r_q[waddr] <= bus.serial_in_r;
      ram_i_q[waddr] <= bus.serial_in_i;
    end
  end

  // Write FSM next state: in_start always restarts the current bank at index 0.
  always_comb begin
    wstate_d = wstate_q;
    wcnt_d   = wcnt_q;
    wbank_d  = wbank_q;
    we       = 1'b0;
    wr_done  = 1'b0;
    wptr     = wcnt_q;
    if (bus.in_valid && (bus.in_start || (wstate_q == StWFill))) begin
      we       = 1'b1;
      wptr     = bus.in_start ? '0 : wcnt_q;
      wstate_d = StWFill;
      if (wptr == LastIdx) begin
        wr_done = 1'b1;
        wbank_d = ~wbank_q;
        wcnt_d  = '0;
      end else begin
        wcnt_d = wptr + AddrW'(1);
      end
    end
  end

  // Read FSM next state and bank-full bookkeeping; a bank finishing this cycle counts as full.
  always_comb begin
    rstate_d = rstate_q;
    rcnt_d   = rcnt_q;
    rbank_d  = rbank_q;
    full_d   = full_q;
    if (wr_done) begin
      full_d[wbank_q] = 1'b1;
    end
    unique case (rstate_q)
      StRIdle: begin
        if (full_d != 2'b00) begin
          rstate_d = StRRun;
          rcnt_d   = '0;
          rbank_d  = full_d[0] ? 1'b0 : 1'b1;
        end
      end
      StRRun: begin
        if (rcnt_q == LastIdx) begin
          full_d[rbank_q] = 1'b0;
          rcnt_d          = '0;
          if (full_d[~rbank_q]) begin
            rbank_d = ~rbank_q;
          end else begin
            rstate_d = StRIdle;
          end
        end else begin
          rcnt_d = rcnt_q + AddrW'(1);
        end
      end
      default: begin
        rstate_d = StRIdle;
      end
    endcase
  end

  // Output stage: one registered bin per running cycle, zeros otherwise.
  always_comb begin
    out_valid_d = 1'b0;
    out_index_d = '0;
    out_r_d     = '0;
    out_i_d     = '0;
    if (rstate_q == StRRun) begin
      out_valid_d = 1'b1;
      out_index_d = rcnt_q;
      out_r_d     = ram_r_q[raddr];
      out_i_d     = ram_i_q[raddr];
    end
    out_first_d = out_valid_d && (out_index_d == '0);
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_first = out_first_q;
  assign bus.out_index = out_index_q;
  assign bus.out_r     = out_r_q;
  assign bus.out_i     = out_i_q;
endmodule
